// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares the RTC parallel-bus cycle engine between three requesters.
//   [0] IRQ service read, [1] user-edit write, [2] display refresh read.
// One transaction runs at a time: IDLE -> LAUNCH -> WAIT -> ACK -> IDLE.
// A completion timeout aborts a transaction whose engine never reports done.
// Optional feature macro: RTC_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (search begins after the last winner); when it is undefined, fixed priority
// [0] > [1] > [2] is used and no pointer register exists.
module rtc_bus_arbiter #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [2:0]      i_req,
  input  logic [2:0]      i_req_we,
  input  logic [3*AW-1:0] i_req_addr,
  input  logic [3*DW-1:0] i_req_wdata,
  output logic [2:0]      o_gnt,
  output logic [2:0]      o_ack,
  output logic            o_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_eng_start,
  output logic            o_eng_we,
  output logic [AW-1:0]   o_eng_addr,
  output logic [DW-1:0]   o_eng_wdata,
  input  logic            i_eng_done,
  input  logic [DW-1:0]   i_eng_rdata,
  output logic            o_busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]    r_state;
  logic [2:0]    r_gnt;
  logic [2:0]    r_ack;
  logic          r_err;
  logic [DW-1:0] r_rdata;
  logic          r_start;
  logic          r_eng_we;
  logic [AW-1:0] r_eng_addr;
  logic [DW-1:0] r_eng_wdata;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [1:0]    w_state_nxt;
  logic [2:0]    w_gnt_nxt;
  logic [2:0]    w_ack_nxt;
  logic          w_err_nxt;
  logic [DW-1:0] w_rdata_nxt;
  logic          w_start_nxt;
  logic          w_eng_we_nxt;
  logic [AW-1:0] w_eng_addr_nxt;
  logic [DW-1:0] w_eng_wdata_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_busy_nxt;

  logic [1:0]    w_win_idx;
  logic          w_any;

`ifdef RTC_ARB_ROUND_ROBIN_EN
  logic [1:0]    r_ptr;
  logic [1:0]    w_ptr_nxt;
  logic [2:0]    w_rr_sum;

  // Round-robin winner: first requester found scanning upward from the pointer.
  always_comb begin
    w_win_idx = 2'd0;
    w_any     = 1'b0;
    w_rr_sum  = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      w_rr_sum = {1'b0, r_ptr} + 3'(k);
      if (w_rr_sum >= 3'd3) begin
        w_rr_sum = w_rr_sum - 3'd3;
      end
      if (i_req[w_rr_sum[1:0]]) begin
        w_win_idx = w_rr_sum[1:0];
        w_any     = 1'b1;
      end
    end
  end
`else
  // Fixed-priority winner: lowest index wins.
  always_comb begin
    w_any = |i_req;
    if (i_req[0]) begin
      w_win_idx = 2'd0;
    end else if (i_req[1]) begin
      w_win_idx = 2'd1;
    end else begin
      w_win_idx = 2'd2;
    end
  end
`endif

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_ack_nxt       = 3'b000;
    w_err_nxt       = r_err;
    w_rdata_nxt     = r_rdata;
    w_start_nxt     = 1'b0;
    w_eng_we_nxt    = r_eng_we;
    w_eng_addr_nxt  = r_eng_addr;
    w_eng_wdata_nxt = r_eng_wdata;
    w_cnt_nxt       = r_cnt;
    w_busy_nxt      = r_busy;
`ifdef RTC_ARB_ROUND_ROBIN_EN
    w_ptr_nxt       = r_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt_nxt       = 3'b001 << w_win_idx;
          w_eng_we_nxt    = i_req_we[w_win_idx];
          w_eng_addr_nxt  = i_req_addr[w_win_idx*AW +: AW];
          w_eng_wdata_nxt = i_req_wdata[w_win_idx*DW +: DW];
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_start_nxt = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_eng_done) begin
          // Completion beats a timeout landing on the same cycle.
          w_rdata_nxt = i_eng_rdata;
          w_err_nxt   = 1'b0;
          w_ack_nxt   = r_gnt;
          w_state_nxt = S_ACK;
        end else if (r_cnt == CNT_MAX) begin
          w_rdata_nxt = '1;
          w_err_nxt   = 1'b1;
          w_ack_nxt   = r_gnt;
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_ACK: begin
        w_gnt_nxt   = 3'b000;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
`ifdef RTC_ARB_ROUND_ROBIN_EN
        if (r_gnt[0]) begin
          w_ptr_nxt = 2'd1;
        end else if (r_gnt[1]) begin
          w_ptr_nxt = 2'd2;
        end else begin
          w_ptr_nxt = 2'd0;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset returns everything to idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= 3'b000;
      r_ack       <= 3'b000;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_start     <= 1'b0;
      r_eng_we    <= 1'b0;
      r_eng_addr  <= '0;
      r_eng_wdata <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
`ifdef RTC_ARB_ROUND_ROBIN_EN
      r_ptr       <= 2'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_start     <= w_start_nxt;
      r_eng_we    <= w_eng_we_nxt;
      r_eng_addr  <= w_eng_addr_nxt;
      r_eng_wdata <= w_eng_wdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
`ifdef RTC_ARB_ROUND_ROBIN_EN
      r_ptr       <= w_ptr_nxt;
`endif
    end
  end

  assign o_gnt       = r_gnt;
  assign o_ack       = r_ack;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_eng_start = r_start;
  assign o_eng_we    = r_eng_we;
  assign o_eng_addr  = r_eng_addr;
  assign o_eng_wdata = r_eng_wdata;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter (TIMEOUT_CYC = 16).
// Directed table, multi-cycle corner sequences, then random traffic against a
// transaction-level model of arbitration, latency, timeout and read data.
module tb_rtc_bus_arbiter;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic [2:0]  i_req;
  logic [2:0]  i_req_we;
  logic [23:0] i_req_addr;
  logic [23:0] i_req_wdata;
  logic [2:0]  o_gnt;
  logic [2:0]  o_ack;
  logic        o_err;
  logic [7:0]  o_rdata;
  logic        o_eng_start;
  logic        o_eng_we;
  logic [7:0]  o_eng_addr;
  logic [7:0]  o_eng_wdata;
  logic        i_eng_done;
  logic [7:0]  i_eng_rdata;
  logic        o_busy;

  rtc_bus_arbiter #(.AW(8), .DW(8), .TIMEOUT_CYC(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (i_req),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_gnt       (o_gnt),
    .o_ack       (o_ack),
    .o_err       (o_err),
    .o_rdata     (o_rdata),
    .o_eng_start (o_eng_start),
    .o_eng_we    (o_eng_we),
    .o_eng_addr  (o_eng_addr),
    .o_eng_wdata (o_eng_wdata),
    .i_eng_done  (i_eng_done),
    .i_eng_rdata (i_eng_rdata),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;  // model's round-robin pointer (unused by fixed priority)

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [23:0] addr;
    logic [23:0] wdata;
    int          done_dly;   // cycles after eng_start; -1 = never
    logic [7:0]  erd;
    bit          drop;
    logic [2:0]  exp_gnt;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Winner chosen by the arbitration rule from a request set.
  function automatic int pick(input logic [2:0] r, input int ptr);
    logic [2:0] rv;
    int idx;
    rv = r;
    for (int k = 0; k < 3; k++) begin
`ifdef RTC_ARB_ROUND_ROBIN_EN
      idx = (ptr + k) % 3;
`else
      idx = k + 0 * ptr;
`endif
      if (rv[idx]) return idx;
    end
    return -1;
  endfunction

  // Runs one transaction from an idle DUT whose request inputs are already set.
  task automatic run_txn(input logic [2:0] exp_gnt, input logic exp_we,
                         input logic [7:0] exp_addr, input logic [7:0] exp_wdata,
                         input int done_dly, input logic [7:0] erd, input bit drop,
                         input logic exp_err, input logic [7:0] exp_rdata, input int exp_lat);
    int  cnt;
    bit  seen;
    tick;
    chk("gnt_at_grant", 32'(o_gnt), 32'(exp_gnt));
    chk("busy_at_grant", 32'(o_busy), 32'd1);
    chk("start_before_launch", 32'(o_eng_start), 32'd0);
    chk("eng_we", 32'(o_eng_we), 32'(exp_we));
    chk("eng_addr", 32'(o_eng_addr), 32'(exp_addr));
    chk("eng_wdata", 32'(o_eng_wdata), 32'(exp_wdata));
    tick;
    chk("eng_start", 32'(o_eng_start), 32'd1);
    i_eng_rdata = erd;
    // Request fields may change freely while the engine is busy.
    i_req_we    = 3'($urandom);
    i_req_addr  = 24'($urandom);
    i_req_wdata = 24'($urandom);
    if (drop) i_req = i_req & ~exp_gnt;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < TO + 8) begin
      i_eng_done = (cnt == done_dly);
      tick;
      cnt++;
      i_eng_done = 1'b0;
      if (o_ack != 3'b000) seen = 1'b1;
      else if (cnt == 1) chk("start_one_cycle", 32'(o_eng_start), 32'd0);
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("ack_latency", 32'(cnt), 32'(exp_lat));
    chk("ack", 32'(o_ack), 32'(exp_gnt));
    chk("gnt_in_ack", 32'(o_gnt), 32'(exp_gnt));
    chk("err", 32'(o_err), 32'(exp_err));
    chk("rdata", 32'(o_rdata), 32'(exp_rdata));
    chk("eng_addr_stable", 32'(o_eng_addr), 32'(exp_addr));
    chk("eng_wdata_stable", 32'(o_eng_wdata), 32'(exp_wdata));
    chk("eng_we_stable", 32'(o_eng_we), 32'(exp_we));
    chk("busy_in_ack", 32'(o_busy), 32'd1);
    i_req = i_req & ~exp_gnt;
    i_eng_done = 1'b1;  // stray completion during ACK must be ignored
    tick;
    i_eng_done = 1'b0;
    chk("ack_pulse_end", 32'(o_ack), 32'd0);
    chk("gnt_release", 32'(o_gnt), 32'd0);
    chk("busy_release", 32'(o_busy), 32'd0);
    chk("err_release", 32'(o_err), 32'd0);
    chk("rdata_hold", 32'(o_rdata), 32'(exp_rdata));
    for (int i = 0; i < 3; i++) if (exp_gnt[i]) m_ptr = (i + 1) % 3;
  endtask

  // Model-driven transaction: expectations come from the current request inputs.
  task automatic run_req(input int done_dly, input logic [7:0] erd, input bit drop);
    int         win;
    logic       e_err;
    int         e_lat;
    logic [7:0] e_rd;
    win   = pick(i_req, m_ptr);
    e_err = !(done_dly >= 0 && done_dly <= TO);
    e_lat = e_err ? TO + 1 : done_dly + 1;
    e_rd  = e_err ? 8'hFF : erd;
    run_txn(3'b001 << win, i_req_we[win], i_req_addr[win*8 +: 8], i_req_wdata[win*8 +: 8],
            done_dly, erd, drop, e_err, e_rd, e_lat);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(o_gnt), 32'd0);
    chk({tag, "_ack"}, 32'(o_ack), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_start"}, 32'(o_eng_start), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_eng_we"}, 32'(o_eng_we), 32'd0);
    chk({tag, "_eng_addr"}, 32'(o_eng_addr), 32'd0);
    chk({tag, "_eng_wdata"}, 32'(o_eng_wdata), 32'd0);
    chk({tag, "_rdata"}, 32'(o_rdata), 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'b010, 3'b010, {8'h90, 8'h21, 8'h10}, {8'hB0, 8'h45, 8'hA0}, 5,  8'h00, 1'b0,
                3'b010, 1'b1, 8'h21, 8'h45, 1'b0, 8'h00, 6};
    vecs[1] = '{3'b100, 3'b000, {8'h44, 8'h22, 8'h11}, {8'h33, 8'h66, 8'h77}, 3,  8'h59, 1'b0,
                3'b100, 1'b0, 8'h44, 8'h33, 1'b0, 8'h59, 4};
    vecs[2] = '{3'b001, 3'b000, {8'h03, 8'h02, 8'h01}, {8'h0C, 8'h0B, 8'h0A}, -1, 8'h5A, 1'b0,
                3'b001, 1'b0, 8'h01, 8'h0A, 1'b1, 8'hFF, 17};
    vecs[3] = '{3'b001, 3'b001, {8'h13, 8'h12, 8'h7E}, {8'h1C, 8'h1B, 8'hE7}, 16, 8'h3C, 1'b0,
                3'b001, 1'b1, 8'h7E, 8'hE7, 1'b0, 8'h3C, 17};
    vecs[4] = '{3'b100, 3'b100, {8'hC5, 8'h42, 8'h41}, {8'h5C, 8'h4B, 8'h4A}, 0,  8'hA5, 1'b0,
                3'b100, 1'b1, 8'hC5, 8'h5C, 1'b0, 8'hA5, 1};
    vecs[5] = '{3'b010, 3'b000, {8'h55, 8'h77, 8'h56}, {8'h99, 8'h88, 8'h98}, 2,  8'h12, 1'b1,
                3'b010, 1'b0, 8'h77, 8'h88, 1'b0, 8'h12, 3};
    vecs[6] = '{3'b011, 3'b010, {8'h33, 8'h22, 8'h11}, {8'h3C, 8'h2C, 8'h1C}, 1,  8'h6D, 1'b0,
                3'b001, 1'b0, 8'h11, 8'h1C, 1'b0, 8'h6D, 2};
    vecs[7] = '{3'b110, 3'b101, {8'hD2, 8'hD1, 8'hD0}, {8'hE2, 8'hE1, 8'hE0}, 17, 8'h00, 1'b0,
                3'b010, 1'b0, 8'hD1, 8'hE1, 1'b1, 8'hFF, 17};

    rst_n = 1'b0; i_req = '0; i_req_we = '0; i_req_addr = '0; i_req_wdata = '0;
    i_eng_done = 1'b0; i_eng_rdata = '0;
    tick; tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      i_req_we = vecs[v].we; i_req_addr = vecs[v].addr; i_req_wdata = vecs[v].wdata;
      i_req = vecs[v].req;
      run_txn(vecs[v].exp_gnt, vecs[v].exp_we, vecs[v].exp_addr, vecs[v].exp_wdata,
              vecs[v].done_dly, vecs[v].erd, vecs[v].drop,
              vecs[v].exp_err, vecs[v].exp_rdata, vecs[v].exp_lat);
      i_req = '0;
    end

    // Three simultaneous reads served back to back, req held until each ack.
    i_req_we = 3'b000; i_req_addr = {8'hA2, 8'hA1, 8'hA0}; i_req_wdata = '0;
    i_req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      i_req_addr = {8'hA2, 8'hA1, 8'hA0};
      i_req_we   = 3'b000;
      run_req(k + 1, 8'hC0 + 8'(k), 1'b0);
    end
    chk("all_served", 32'(i_req), 32'd0);

    // Completion pulses while idle produce nothing.
    for (int k = 0; k < 3; k++) begin
      i_eng_done = 1'b1;
      tick;
      i_eng_done = 1'b0;
      chk("idle_done_ack", 32'(o_ack), 32'd0);
      chk("idle_done_busy", 32'(o_busy), 32'd0);
    end

    // Async reset in WAIT: immediate return to idle, then pending request relaunches.
    i_req_we = 3'b000; i_req_addr = {8'h00, 8'h00, 8'h6B}; i_req_wdata = '0;
    i_req = 3'b001;
    tick; tick; tick;
    chk("pre_reset_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick;
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    m_ptr = 0;
    i_req_addr = {8'h00, 8'h00, 8'h6B};
    run_req(2, 8'h4E, 1'b0);

    // Random traffic checked against the model.
    for (int r = 0; r < 30; r++) begin
      i_req_we    = 3'($urandom);
      i_req_addr  = 24'($urandom);
      i_req_wdata = 24'($urandom);
      i_req       = 3'($urandom_range(0, 7));
      if (i_req == 3'b000) begin
        i_eng_done = 1'($urandom);
        tick;
        i_eng_done = 1'b0;
        chk("rand_idle_busy", 32'(o_busy), 32'd0);
        chk("rand_idle_ack", 32'(o_ack), 32'd0);
      end else begin
        for (int g = 0; g < 3 && i_req != 3'b000; g++) begin
          int dly;
          dly = $urandom_range(0, 20);
          if (dly == 20) dly = -1;
          run_req(dly, 8'($urandom), ($urandom_range(0, 3) == 0));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
